// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU op sequencer: opcodes, FSM states and
// instruction field positions.
package alu_seq_pkg;

    localparam int unsigned INSTR_W = 10;

    localparam int unsigned OP_MSB  = 9;
    localparam int unsigned OP_LSB  = 6;
    localparam int unsigned RD_MSB  = 5;
    localparam int unsigned RD_LSB  = 4;
    localparam int unsigned RS1_MSB = 3;
    localparam int unsigned RS1_LSB = 2;
    localparam int unsigned RS2_MSB = 1;
    localparam int unsigned RS2_LSB = 0;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOTA = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_XNOR = 4'd9;
    localparam logic [3:0] OP_LDI  = 4'd15;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StWb
    } state_e;

    function automatic logic op_is_alu(input logic [3:0] op);
        return op <= OP_XNOR;
    endfunction

    function automatic logic op_is_ldi(input logic [3:0] op);
        return op == OP_LDI;
    endfunction

endpackage

// File: rtl/seq_regfile.sv
// Small register file: two combinational read ports, one debug read port and
// one synchronous write port, all cleared by synchronous reset.
module seq_regfile #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned RADDR_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [RADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [RADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0]  rdata_a,
    input  logic [RADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0]  rdata_b,
    input  logic [RADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    localparam int unsigned NREGS = 2 ** RADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata_a  = regs_q[raddr_a];
    assign rdata_b  = regs_q[raddr_b];
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Four-phase control stage for the external flag ALU: accepts one instruction,
// reads operands, drives the ALU, then writes result and flags back.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned RADDR_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [3:0]         alu_sel,
    input  logic [DATA_W-1:0]  alu_y,
    input  logic               alu_c,
    input  logic               alu_z,
    input  logic               alu_n,
    output logic               done,
    output logic               err,
    output logic [2:0]         flags,
    input  logic [RADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    state_e state_q, state_d;

    logic [INSTR_W-1:0] instr_q;
    logic [DATA_W-1:0]  y_q;
    logic               c_q, z_q, n_q;
    logic [2:0]         flags_d;

    logic [3:0]         op;
    logic [RADDR_W-1:0] rd, rs1, rs2;
    logic [DATA_W-1:0]  imm;
    logic               is_alu, is_ldi, is_illegal;

    logic               we;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  rdata_a, rdata_b;

    assign op  = instr_q[OP_MSB:OP_LSB];
    assign rd  = instr_q[RD_MSB:RD_LSB];
    assign rs1 = instr_q[RS1_MSB:RS1_LSB];
    assign rs2 = instr_q[RS2_MSB:RS2_LSB];
    // LDI reuses the two source fields as a 4-bit immediate
    assign imm = DATA_W'({rs1, rs2});

    assign is_alu     = op_is_alu(op);
    assign is_ldi     = op_is_ldi(op);
    assign is_illegal = !is_alu && !is_ldi;

    seq_regfile #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (rd),
        .wdata    (wdata),
        .raddr_a  (rs1),
        .rdata_a  (rdata_a),
        .raddr_b  (rs2),
        .rdata_b  (rdata_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        we          = 1'b0;
        wdata       = y_q;
        flags_d     = flags;
        unique case (state_q)
            StIdle: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_d = StRead;
                end
            end
            StRead: state_d = StExec;
            StExec: state_d = StWb;
            StWb: begin
                state_d = StIdle;
                if (is_ldi) begin
                    we      = 1'b1;
                    wdata   = imm;
                    flags_d = {1'b0, imm == '0, 1'b0};
                end else if (is_alu) begin
                    we      = 1'b1;
                    flags_d = {c_q, z_q, n_q};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            y_q     <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            flags   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            // Retire pulses land together with the writeback they report
            done <= (state_q == StWb);
            err  <= (state_q == StWb) && is_illegal;
            if (instr_valid && instr_ready) begin
                instr_q <= instr;
            end
            if (state_q == StRead) begin
                alu_a   <= rdata_a;
                alu_b   <= rdata_b;
                alu_sel <= op;
            end
            if (state_q == StExec) begin
                y_q <= alu_y;
                c_q <= alu_c;
                z_q <= alu_z;
                n_q <= alu_n;
            end
            if (state_q == StWb) begin
                flags <= flags_d;
            end
        end
    end

endmodule
